// File: rtl/bin_to_bcd_seq.sv
// Purpose : sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock,
//           feeding a row of per-digit seven-segment decoders.
// Latency : start accepted at edge 0; bcd_out/done/display_write update at edge WIDTH+1.
// Backpr. : no queueing; start is only sampled while idle (busy low) and is dropped otherwise.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   start          conversion request, sampled only in IDLE
//   bin_in         unsigned binary value, captured on the accepting edge
//   busy           high while a conversion is in flight (SHIFT and DONE states)
//   done           one-cycle pulse, bcd_out has just been updated
//   display_write  copy of done, fans out to every decoder's displayWrite
//   bcd_out        packed BCD, digit k in [4k+3:4k], held between conversions
//   overflow       (only with BIN_TO_BCD_OVERFLOW_EN) input exceeded 10^DIGITS-1
//
// Optional feature macro: BIN_TO_BCD_OVERFLOW_EN. When defined, out-of-range inputs
// saturate bcd_out to all nines and raise overflow. When undefined, results wrap
// modulo 10^DIGITS.

module bin_to_bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic                  display_write,
`ifdef BIN_TO_BCD_OVERFLOW_EN
    output logic                  overflow,
`endif
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       shift_q, shift_d;
    logic [BW-1:0]          scratch_q, scratch_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BW-1:0]          bcd_q;
    logic                   done_q;
    logic                   publish;
    logic [BW-1:0]          adj;
    logic [BW+WIDTH-1:0]    cat_shl;
    logic [BW-1:0]          result;

    // Pre-shift correction: any digit >= 5 would become >= 10 after doubling,
    // so bump it by 3 so the doubling carries cleanly into the next nibble.
    function automatic logic [BW-1:0] add3(input logic [BW-1:0] s);
        logic [BW-1:0] r;
        r = s;
        for (int k = 0; k < DIGITS; k++) begin
            if (s[4*k +: 4] >= 4'd5) begin
                r[4*k +: 4] = s[4*k +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

`ifdef BIN_TO_BCD_OVERFLOW_EN
    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

    localparam longint unsigned BCD_MAX = pow10(DIGITS) - 1;

    logic ovf_pend_q, ovf_pend_d;
    logic overflow_q;

    assign result = ovf_pend_q ? {DIGITS{4'h9}} : scratch_q;
`else
    assign result = scratch_q;
`endif

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        publish   = 1'b0;
        adj       = add3(scratch_q);
        // Scratch and shift register behave as one long register; the scratch
        // MSB falls off the top, which is what makes narrow outputs wrap mod 10^DIGITS.
        cat_shl   = {adj, shift_q} << 1;
`ifdef BIN_TO_BCD_OVERFLOW_EN
        ovf_pend_d = ovf_pend_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shift_d   = bin_in;
                    scratch_d = '0;
                    cnt_d     = CW'(WIDTH);
`ifdef BIN_TO_BCD_OVERFLOW_EN
                    ovf_pend_d = (64'(bin_in) > BCD_MAX);
`endif
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                scratch_d = cat_shl[BW+WIDTH-1 -: BW];
                shift_d   = cat_shl[WIDTH-1:0];
                cnt_d     = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Scratch is final here; the result is published as control
                // returns to IDLE, so a held start can be accepted on the very next edge.
                publish = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            done_q    <= publish;
            if (publish) begin
                bcd_q <= result;
            end
        end
    end

`ifdef BIN_TO_BCD_OVERFLOW_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_pend_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            ovf_pend_q <= ovf_pend_d;
            if (publish) begin
                overflow_q <= ovf_pend_q;
            end
        end
    end

    assign overflow = overflow_q;
`endif

    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;
    assign display_write = done_q;
    assign bcd_out       = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        start_a, start_b;
    logic [7:0]  bin_a, bin_b;
    logic        busy_a, busy_b, done_a, done_b, dw_a, dw_b;
    logic [11:0] bcd_a;
    logic [7:0]  bcd_b;
`ifdef BIN_TO_BCD_OVERFLOW_EN
    logic        ovf_a, ovf_b;
`endif

    int total = 0;
    int bad   = 0;

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .bin_in(bin_a),
        .busy(busy_a), .done(done_a), .display_write(dw_a),
`ifdef BIN_TO_BCD_OVERFLOW_EN
        .overflow(ovf_a),
`endif
        .bcd_out(bcd_a)
    );

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .bin_in(bin_b),
        .busy(busy_b), .done(done_b), .display_write(dw_b),
`ifdef BIN_TO_BCD_OVERFLOW_EN
        .overflow(ovf_b),
`endif
        .bcd_out(bcd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (bad=%0d)", bad);
        $fatal(1);
    end

    typedef struct {
        int unsigned bin;
        logic [11:0] bcd;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: decimal digits by plain division, value taken mod 10^digits,
    // or saturated to all nines when the overflow option is built in.
    function automatic logic [11:0] model_bcd(input int unsigned v, input int digits);
        int unsigned lim;
        int unsigned x;
        logic [11:0] r;
        lim = (digits == 2) ? 100 : 1000;
        r = '0;
`ifdef BIN_TO_BCD_OVERFLOW_EN
        if (v >= lim) begin
            for (int i = 0; i < digits; i++) r[4*i +: 4] = 4'd9;
            return r;
        end
`endif
        x = v % lim;
        for (int i = 0; i < digits; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic get_done(input int sel);
        return (sel == 0) ? done_a : done_b;
    endfunction
    function automatic logic get_dw(input int sel);
        return (sel == 0) ? dw_a : dw_b;
    endfunction
    function automatic logic get_busy(input int sel);
        return (sel == 0) ? busy_a : busy_b;
    endfunction
    function automatic logic [11:0] get_bcd(input int sel);
        return (sel == 0) ? bcd_a : {4'h0, bcd_b};
    endfunction
`ifdef BIN_TO_BCD_OVERFLOW_EN
    function automatic logic get_ovf(input int sel);
        return (sel == 0) ? ovf_a : ovf_b;
    endfunction
`endif

    task automatic drive(input int sel, input logic s, input logic [7:0] b);
        if (sel == 0) begin
            start_a = s;
            bin_a   = b;
        end else begin
            start_b = s;
            bin_b   = b;
        end
    endtask

    // Starts a conversion, then watches 20 cycles. k = index of the edge just
    // before each falling-edge sample (edge 0 accepts start). bin_in is scrambled
    // after acceptance; a second start is pulsed into edge glitch_k+1 if glitch_k >= 0.
    task automatic convert(input int sel, input int unsigned v, input int glitch_k,
                           output int lat, output logic [11:0] got, output int pulses,
                           output logic [19:0] busy_mask, output int dw_bad);
        lat = -1; got = '0; pulses = 0; busy_mask = '0; dw_bad = 0;
        @(negedge clk);
        drive(sel, 1'b1, v[7:0]);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            busy_mask[k] = get_busy(sel);
            if (get_dw(sel) !== get_done(sel)) dw_bad++;
            if (get_done(sel) === 1'b1) begin
                pulses++;
                if (lat < 0) begin
                    lat = k;
                    got = get_bcd(sel);
                end
            end
            if (k == glitch_k) drive(sel, 1'b1, 8'd7);
            else               drive(sel, 1'b0, 8'($urandom));
        end
    endtask

    task automatic do_conv(input int sel, input int unsigned v, input int glitch_k,
                           input logic [11:0] exp);
        int lat, pulses, dw_bad;
        logic [11:0] got;
        logic [19:0] bm;
        convert(sel, v, glitch_k, lat, got, pulses, bm, dw_bad);
        check($sformatf("latency u%0d v=%0d", sel, v), 64'(lat), 64'd9);
        check($sformatf("bcd u%0d v=%0d", sel, v), 64'(got), 64'(exp));
        check($sformatf("done_pulses u%0d v=%0d", sel, v), 64'(pulses), 64'd1);
        check($sformatf("busy_profile u%0d v=%0d", sel, v), 64'(bm), 64'h001FF);
        check($sformatf("dw_eq_done u%0d v=%0d", sel, v), 64'(dw_bad), 64'd0);
`ifdef BIN_TO_BCD_OVERFLOW_EN
        check($sformatf("overflow u%0d v=%0d", sel, v), 64'(get_ovf(sel)),
              64'((sel == 1) && (v > 99)));
`endif
    endtask

    initial begin
        logic [11:0] prev;
        int n, first, prevk, cnt_bad, pulses;
        int unsigned v;
        int sel;

        vecs[0] = '{0,   12'h000};
        vecs[1] = '{255, 12'h255};
        vecs[2] = '{42,  12'h042};
        vecs[3] = '{7,   12'h007};
        vecs[4] = '{10,  12'h010};
        vecs[5] = '{100, 12'h100};
        vecs[6] = '{199, 12'h199};
        vecs[7] = '{128, 12'h128};
        vecs[8] = '{9,   12'h009};
        vecs[9] = '{250, 12'h250};

        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; bin_a = '0; bin_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy",  64'({busy_a, busy_b}), 64'd0);
        check("reset done",  64'({done_a, done_b, dw_a, dw_b}), 64'd0);
        check("reset bcd_a", 64'(bcd_a), 64'd0);
        check("reset bcd_b", 64'(bcd_b), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) do_conv(0, vecs[i].bin, -1, vecs[i].bcd);

        // bcd_out must hold with start low
        prev = bcd_a; cnt_bad = 0;
        repeat (15) begin
            @(negedge clk);
            if (bcd_a !== prev || done_a !== 1'b0 || busy_a !== 1'b0) cnt_bad++;
        end
        check("hold idle", 64'(cnt_bad), 64'd0);

        // start during SHIFT is ignored
        do_conv(0, 99, 2, 12'h099);

        // asynchronous reset mid-conversion
        @(negedge clk); drive(0, 1'b1, 8'd200);
        @(posedge clk);
        @(negedge clk); drive(0, 1'b0, 8'd200);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset busy", 64'(busy_a), 64'd0);
        check("midreset done", 64'({done_a, dw_a}), 64'd0);
        check("midreset bcd",  64'(bcd_a), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        pulses = 0;
        repeat (15) begin
            @(negedge clk);
            if (done_a === 1'b1) pulses++;
        end
        check("midreset no done", 64'(pulses), 64'd0);
        do_conv(0, 42, -1, 12'h042);

        // start held high: back-to-back conversions every 10 cycles
        @(negedge clk); drive(0, 1'b1, 8'd128);
        n = 0; first = -1; prevk = 0; cnt_bad = 0;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            if (done_a === 1'b1) begin
                if (n == 0) first = k;
                else if (k - prevk != 10) cnt_bad++;
                if (bcd_a !== 12'h128) cnt_bad++;
                prevk = k;
                n++;
            end
        end
        drive(0, 1'b0, 8'd0);
        check("b2b count", 64'(n), 64'd4);
        check("b2b first", 64'(first), 64'd9);
        check("b2b spacing/value", 64'(cnt_bad), 64'd0);
        repeat (25) @(negedge clk);

        // two-digit instance: out-of-range then in-range
`ifdef BIN_TO_BCD_OVERFLOW_EN
        do_conv(1, 150, -1, 12'h099);
`else
        do_conv(1, 150, -1, 12'h050);
`endif
        do_conv(1, 42, -1, 12'h042);

        // randomized values against the arithmetic model
        for (int i = 0; i < 24; i++) begin
            v   = $urandom_range(0, 255);
            sel = int'($urandom_range(0, 1));
            do_conv(sel, v, -1, model_bcd(v, (sel == 0) ? 3 : 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
